// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data memory: round-robin by default,
// with a bounded lock that lets one requester run short bursts while the other waits.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [0:ADDR_WIDTH-1] addr0,
  input  logic [0:ADDR_WIDTH-1] addr1,
  input  logic [0:DATA_WIDTH-1] wdata0,
  input  logic [0:DATA_WIDTH-1] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [0:DATA_WIDTH-1] rdata0,
  output logic [0:DATA_WIDTH-1] rdata1,
  output logic                  mem_En,
  output logic                  mem_WrEn,
  output logic [0:ADDR_WIDTH-1] mem_addr,
  output logic [0:DATA_WIDTH-1] mem_di,
  input  logic [0:DATA_WIDTH-1] mem_do
);

  localparam logic [1:0] OwnNone = 2'd0;
  localparam logic [1:0] Own0    = 2'd1;
  localparam logic [1:0] Own1    = 2'd2;
  localparam logic [3:0] MaxLock = 4'(MAX_LOCK);

  logic       last_q, last_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;

  logic       hold0, hold1, pick1;
  logic       win_lock, other_wait;
  logic [1:0] win_own;
  logic [3:0] cnt_base;

  // Arbitration: a lock owner under its budget keeps the memory, else round-robin.
  always_comb begin
    hold0 = (owner_q == Own0) && lock0 && (lock_cnt_q < MaxLock);
    hold1 = (owner_q == Own1) && lock1 && (lock_cnt_q < MaxLock);
    if (req0 && req1) begin
      if (hold1) begin
        pick1 = 1'b1;
      end else if (hold0) begin
        pick1 = 1'b0;
      end else begin
        pick1 = ~last_q;
      end
    end else begin
      pick1 = req1;
    end
    gnt1 = reset & req1 & pick1;
    gnt0 = reset & req0 & ~pick1;
  end

  always_comb begin
    mem_En   = gnt0 | gnt1;
    mem_WrEn = gnt1 ? wr1 : (gnt0 & wr0);
    mem_addr = gnt1 ? addr1 : addr0;
    mem_di   = gnt1 ? wdata1 : wdata0;
  end

  always_comb begin
    last_d     = last_q;
    owner_d    = OwnNone;
    lock_cnt_d = '0;
    win_lock   = gnt1 ? lock1 : lock0;
    other_wait = gnt1 ? req0 : req1;
    win_own    = gnt1 ? Own1 : Own0;
    cnt_base   = '0;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      if (win_lock) begin
        owner_d = win_own;
        // A new owner starts its burst budget from zero.
        cnt_base = (owner_q == win_own) ? lock_cnt_q : 4'd0;
        if (other_wait && (cnt_base < MaxLock)) begin
          lock_cnt_d = cnt_base + 4'd1;
        end else begin
          lock_cnt_d = cnt_base;
        end
      end
    end
    rvalid0_d = gnt0 & ~wr0;
    rvalid1_d = gnt1 & ~wr1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;
      owner_q    <= OwnNone;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      last_q     <= last_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  always_comb begin
    rvalid0 = rvalid0_q;
    rvalid1 = rvalid1_q;
    rdata0  = rvalid0_q ? mem_do : '0;
    rdata1  = rvalid1_q ? mem_do : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x64 synchronous memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1, wr0, wr1;
  logic [0:7]  addr0, addr1;
  logic [0:63] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [0:63] rdata0, rdata1;
  logic        mem_En, mem_WrEn;
  logic [0:7]  mem_addr;
  logic [0:63] mem_di;
  logic [0:63] mem_do;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] Beef = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] W1   = 64'h1111_2222_3333_4444;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(8),
    .MAX_LOCK  (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .lock0   (lock0),
    .lock1   (lock1),
    .wr0     (wr0),
    .wr1     (wr1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .mem_En  (mem_En),
    .mem_WrEn(mem_WrEn),
    .mem_addr(mem_addr),
    .mem_di  (mem_di),
    .mem_do  (mem_do)
  );

  function automatic logic [63:0] pat(input int a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  // Memory model; contents preloaded with pat(addr) on the first edge.
  logic [63:0] mem [256];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else if (mem_En) begin
      if (mem_WrEn) mem[mem_addr] <= mem_di;
      else          mem_do <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_inv(input string tag);
    check({tag, "_gnt_excl"}, 64'(gnt0 & gnt1), 64'd0);
    check({tag, "_rv_excl"}, 64'(rvalid0 & rvalid1), 64'd0);
    check({tag, "_mem_en"}, 64'(mem_En), 64'(gnt0 | gnt1));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 8'h05; addr1 = 8'h00; wdata0 = '0; wdata1 = '0;

    // Reset with req0 held
    #3;
    check("rst_gnt0", 64'(gnt0), 64'd0);
    check("rst_mem_en", 64'(mem_En), 64'd0);
    check("rst_rvalid0", 64'(rvalid0), 64'd0);
    cyc(); #2;
    check("rst_gnt0_edge", 64'(gnt0), 64'd0);
    cyc(); reset = 1'b1; #2;
    check("rel_gnt0", 64'(gnt0), 64'd1);
    check("rel_addr", 64'(mem_addr), 64'h05);
    check("rel_wren", 64'(mem_WrEn), 64'd0);
    cyc(); req0 = 1'b0; #2;
    check("rel_rvalid0", 64'(rvalid0), 64'd1);
    check("rel_rdata0", rdata0, pat(5));
    check("rel_rvalid1", 64'(rvalid1), 64'd0);

    // Core write then read-back
    cyc(); req0 = 1'b1; wr0 = 1'b1; wdata0 = Beef; #2;
    check("wr_gnt0", 64'(gnt0), 64'd1);
    check("wr_wren", 64'(mem_WrEn), 64'd1);
    check("wr_di", mem_di, Beef);
    check_inv("wr");
    cyc(); wr0 = 1'b0; #2;
    check("rd_gnt0", 64'(gnt0), 64'd1);
    check("rd_wren", 64'(mem_WrEn), 64'd0);
    check("wr_no_rvalid", 64'(rvalid0), 64'd0);
    cyc(); req0 = 1'b0; #2;
    check("rd_rvalid0", 64'(rvalid0), 64'd1);
    check("rd_rdata0", rdata0, Beef);
    check("rd_rvalid1", 64'(rvalid1), 64'd0);
    cyc(); #2;
    check("idle_rdata0", rdata0, 64'd0);

    // Requester 1 write sets last=1, then contested round-robin
    cyc(); req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h20; wdata1 = W1; #2;
    check("w1_gnt1", 64'(gnt1), 64'd1);
    check("w1_wren", 64'(mem_WrEn), 64'd1);
    cyc(); wr1 = 1'b0; req0 = 1'b1; addr0 = 8'h10;
    for (int i = 0; i < 6; i++) begin
      #2;
      check($sformatf("rr_gnt0_%0d", i), 64'(gnt0), 64'(i % 2 == 0));
      check($sformatf("rr_gnt1_%0d", i), 64'(gnt1), 64'(i % 2 == 1));
      check_inv("rr");
      if (i > 0) begin
        check($sformatf("rr_rv0_%0d", i), 64'(rvalid0), 64'((i - 1) % 2 == 0));
        if ((i - 1) % 2 == 0) check($sformatf("rr_rd0_%0d", i), rdata0, pat(16));
        else                  check($sformatf("rr_rd1_%0d", i), rdata1, W1);
      end
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0; #2;
    check("rr_tail_rv1", 64'(rvalid1), 64'd1);
    check("rr_tail_rd1", rdata1, W1);
    cyc();

    // Locked burst from requester 1, contested by requester 0
    req1 = 1'b1; lock1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2; check("lk_pre_gnt1", 64'(gnt1), 64'd1); cyc();
    end
    req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("lk_gnt0_%0d", i), 64'(gnt0), 64'(i == 4 || i == 9));
      check($sformatf("lk_gnt1_%0d", i), 64'(gnt1), 64'(i != 4 && i != 9));
      if (i == 5) begin
        check("lk_rv0", 64'(rvalid0), 64'd1);
        check("lk_rd0", rdata0, pat(16));
      end
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0; #2; cyc();

    // Uncontested lock never advances the budget
    req1 = 1'b1; lock1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2; check($sformatf("ul_gnt1_%0d", i), 64'(gnt1), 64'd1); cyc();
    end
    req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2; check($sformatf("ul_gnt0_%0d", i), 64'(gnt0), 64'(i == 4)); cyc();
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0; #2; cyc();

    // Reset half a cycle after a requester 1 read grant
    req1 = 1'b1; addr1 = 8'h20; #2;
    check("mr_gnt1", 64'(gnt1), 64'd1);
    cyc(); #2;
    check("mr_rv1_pre", 64'(rvalid1), 64'd1);
    #2; reset = 1'b0; #1;
    check("mr_rv1_rst", 64'(rvalid1), 64'd0);
    check("mr_rd1_rst", rdata1, 64'd0);
    check("mr_gnt1_rst", 64'(gnt1), 64'd0);
    check("mr_en_rst", 64'(mem_En), 64'd0);
    cyc(); #2;
    check("mr_rv1_hold", 64'(rvalid1), 64'd0);
    check("mr_gnt1_hold", 64'(gnt1), 64'd0);
    cyc(); reset = 1'b1; #2;
    check("mr_gnt1_rel", 64'(gnt1), 64'd1);
    check("mr_rv1_rel", 64'(rvalid1), 64'd0);
    cyc(); req1 = 1'b0; #2;
    check("mr_rv1_post", 64'(rvalid1), 64'd1);
    check("mr_rd1_post", rdata1, W1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
